cart_bus_responder: RTL and testbench

- Cartridge-side end of the Game Boy cartridge bus: emulates an MBC5 cartridge answering the console's bus master, which drives CART_A/CART_CS/CART_RD/CART_WR/CART_CLK and tri-states CART_D.
- Synchronises the asynchronous pins into hclk and decodes reads and writes.
- Holds the MBC5 bank registers and fetches ROM/SRAM bytes through a single-outstanding req/ack memory port.
- Drives read data back onto the bus. Used for cart-slot loopback and for a flash-cart personality.

---
 rtl/cart_pkg.sv | 22 ++
 rtl/cart_pin_sync.sv | 52 +++++
 rtl/cart_bus_responder.sv | 219 +++++++++++++++++++++
 tb/tb_cart_bus_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the MBC5 cartridge bus responder.
package cart_pkg;

  // IDLE wait for bus | SETTLE debounce pins | FETCH read outstanding | HOLD drive bus | WRITE SRAM store
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_FETCH, ST_HOLD, ST_WRITE} cart_state_e;

  localparam int unsigned ADDR_W = 23;

  localparam logic [15:0] ROM0_LIMIT = 16'h3FFF;
  localparam logic [15:0] ROMX_BASE  = 16'h4000;
  localparam logic [15:0] ROMX_LIMIT = 16'h7FFF;
  localparam logic [15:0] SRAM_BASE  = 16'hA000;
  localparam logic [15:0] SRAM_LIMIT = 16'hBFFF;

  localparam logic [15:0] MBC_RAMEN_LIMIT   = 16'h1FFF;
  localparam logic [15:0] MBC_ROMB_LO_LIMIT = 16'h2FFF;
  localparam logic [15:0] MBC_ROMB_HI_LIMIT = 16'h3FFF;
  localparam logic [15:0] MBC_RAMB_LIMIT    = 16'h5FFF;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

endpackage

// File: rtl/cart_pin_sync.sv
// Two-flop synchronisers for the cartridge pins, with strobe edge and pin-change detection.
module cart_pin_sync (
  input  logic        hclk,
  input  logic        rst,
  input  logic [15:0] cart_a,
  input  logic        cart_cs_n,
  input  logic        cart_rd_n,
  input  logic        cart_wr_n,
  input  logic [7:0]  cart_d_in,
  output logic [15:0] a_s,
  output logic        cs_n_s,
  output logic        rd_n_s,
  output logic        wr_n_s,
  output logic [7:0]  d_s,
  output logic        rd_fall,
  output logic        wr_rise,
  output logic        a_chg,
  output logic        any_chg
);

  // strobes idle high so leaving reset does not look like a bus edge
  localparam logic [26:0] PIN_RST  = {16'h0000, 3'b111, 8'h00};
  localparam logic [18:0] PREV_RST = {16'h0000, 3'b111};

  logic [26:0] meta_q, meta_d, sync_q, sync_d;
  logic [18:0] prev_q, prev_d;

  always_comb begin
    meta_d = {cart_a, cart_cs_n, cart_rd_n, cart_wr_n, cart_d_in};
    sync_d = meta_q;
    prev_d = sync_q[26:8];
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      meta_q <= PIN_RST;
      sync_q <= PIN_RST;
      prev_q <= PREV_RST;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign {a_s, cs_n_s, rd_n_s, wr_n_s, d_s} = sync_q;
  assign rd_fall = prev_q[1] & ~rd_n_s;
  assign wr_rise = ~prev_q[0] & wr_n_s;
  assign a_chg   = prev_q[18:3] != a_s;
  assign any_chg = prev_q != sync_q[26:8];

endmodule

// File: rtl/cart_bus_responder.sv
// MBC5 cartridge responder: synchronised bus decode, bank registers and a req/ack fetch FSM.
// Build option CART_RUMBLE_EN adds the rumble output (ram_bank[3]) and limits RAM banking to bits [2:0].
module cart_bus_responder
  import cart_pkg::*;
#(
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned ROM_BANK_BITS = 9,
  parameter int unsigned RAM_BANK_BITS = 4
) (
  input  logic        hclk,
  input  logic        gbreset,
  input  logic [15:0] cart_a,
  input  logic        cart_cs_n,
  input  logic        cart_rd_n,
  input  logic        cart_wr_n,
  input  logic [7:0]  cart_d_in,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_ram,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        ram_en
`ifdef CART_RUMBLE_EN
  ,
  output logic        rumble
`endif
);

  localparam int unsigned CNT_W = $clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  logic [15:0] a_s;
  logic        cs_n_s, rd_n_s, wr_n_s, rd_fall, wr_rise, a_chg, any_chg;
  logic [7:0]  d_s;

  cart_pin_sync u_sync (
    .hclk(hclk), .rst(gbreset),
    .cart_a(cart_a), .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
    .cart_d_in(cart_d_in),
    .a_s(a_s), .cs_n_s(cs_n_s), .rd_n_s(rd_n_s), .wr_n_s(wr_n_s), .d_s(d_s),
    .rd_fall(rd_fall), .wr_rise(wr_rise), .a_chg(a_chg), .any_chg(any_chg)
  );

  cart_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     req_q, req_d, we_q, we_d, sel_q, sel_d;
  logic [ADDR_W-1:0]        addr_q, addr_d, pwa_q, pwa_d;
  logic [7:0]               wdata_q, wdata_d, dout_q, dout_d, wd_q, wd_d, pwd_q, pwd_d;
  logic                     stale_q, stale_d, pw_q, pw_d;
  logic [ROM_BANK_BITS-1:0] rom_bank_q, rom_bank_d;
  logic [RAM_BANK_BITS-1:0] ram_bank_q, ram_bank_d, ram_bank_eff;
  logic                     ram_en_q, ram_en_d;
  logic                     rom0, romx, sram, hit, ack, wr_sram, rd_cycle;
  logic [ADDR_W-1:0]        rd_addr, ram_addr;

  always_comb begin
    rom0 = a_s <= ROM0_LIMIT;
    romx = (a_s >= ROMX_BASE) && (a_s <= ROMX_LIMIT);
    sram = (a_s >= SRAM_BASE) && (a_s <= SRAM_LIMIT) && !cs_n_s && ram_en_q;
    hit  = rom0 | romx | sram;
    ram_bank_eff = ram_bank_q;
`ifdef CART_RUMBLE_EN
    ram_bank_eff[RAM_BANK_BITS-1:3] = '0;
`endif
    ram_addr = ADDR_W'({ram_bank_eff, a_s[12:0]});
    if (sram)      rd_addr = ram_addr;
    else if (romx) rd_addr = ADDR_W'({rom_bank_q, a_s[13:0]});
    else           rd_addr = ADDR_W'({{ROM_BANK_BITS{1'b0}}, a_s[13:0]});
    ack      = mem_ack & req_q;
    wr_sram  = wr_rise & sram;
    rd_cycle = !rd_n_s & wr_n_s;
  end

  // bus data is sampled continuously while WR is low; the register update uses the last sample
  always_comb begin
    wd_d       = wr_n_s ? wd_q : d_s;
    rom_bank_d = rom_bank_q;
    ram_bank_d = ram_bank_q;
    ram_en_d   = ram_en_q;
    if (wr_rise && !a_s[15]) begin
      if (a_s <= MBC_RAMEN_LIMIT)        ram_en_d = wd_q[3:0] == RAM_EN_KEY;
      else if (a_s <= MBC_ROMB_LO_LIMIT) rom_bank_d[7:0] = wd_q;
      else if (a_s <= MBC_ROMB_HI_LIMIT) rom_bank_d[ROM_BANK_BITS-1] = wd_q[0];
      else if (a_s <= MBC_RAMB_LIMIT)    ram_bank_d = wd_q[RAM_BANK_BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    dout_d  = dout_q;
    pw_d    = pw_q;
    pwa_d   = pwa_q;
    pwd_d   = pwd_q;
    req_d   = req_q & ~ack;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // SRAM writes are parked here so a read in flight can finish before the store issues
    if (wr_sram) begin
      pw_d  = 1'b1;
      pwa_d = ram_addr;
      pwd_d = wd_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (wr_sram) state_d = ST_WRITE;
        else if (rd_cycle && (a_chg || rd_fall)) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (wr_sram)              state_d = ST_WRITE;
        else if (!rd_cycle)       state_d = ST_IDLE;
        else if (any_chg)         cnt_d = CNT_LOAD;
        else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
        else if (hit) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = sram;
          addr_d  = rd_addr;
          stale_d = 1'b0;
        end else                  state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (a_chg) stale_d = 1'b1;
        if (ack) begin
          if (pw_d)                      state_d = ST_WRITE;
          else if (!rd_cycle)            state_d = ST_IDLE;
          else if (stale_q || a_chg) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_LOAD;
          end else begin
            dout_d  = mem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (wr_sram)        state_d = ST_WRITE;
        else if (!rd_cycle) state_d = ST_IDLE;
        else if (a_chg) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WRITE: begin
        if (pw_q && !req_q) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 1'b1;
          addr_d  = pwa_q;
          wdata_d = pwd_q;
          pw_d    = 1'b0;
        end else if (!pw_q && ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge gbreset) begin
    if (gbreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stale_q    <= 1'b0;
      dout_q     <= '0;
      pw_q       <= 1'b0;
      pwa_q      <= '0;
      pwd_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wd_q       <= '0;
      rom_bank_q <= ROM_BANK_BITS'(1);
      ram_bank_q <= '0;
      ram_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
      dout_q     <= dout_d;
      pw_q       <= pw_d;
      pwa_q      <= pwa_d;
      pwd_q      <= pwd_d;
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wd_q       <= wd_d;
      rom_bank_q <= rom_bank_d;
      ram_bank_q <= ram_bank_d;
      ram_en_q   <= ram_en_d;
    end
  end

  assign cart_d_out  = dout_q;
  assign cart_d_oe   = rd_cycle & hit & (state_q == ST_HOLD);
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_sel_ram = sel_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign ram_en      = ram_en_q;
`ifdef CART_RUMBLE_EN
  assign rumble      = ram_bank_q[3];
`endif

endmodule

// File: tb/tb_cart_bus_responder.sv
// Scoreboard bench for cart_bus_responder: directed bus cycles, queued expected requests and read data.
module tb_cart_bus_responder;

  logic        hclk = 1'b0;
  logic        gbreset;
  logic [15:0] cart_a;
  logic        cart_cs_n, cart_rd_n, cart_wr_n;
  logic [7:0]  cart_d_in, cart_d_out;
  logic        cart_d_oe;
  logic        mem_req, mem_we, mem_sel_ram, mem_ack;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        ram_en;
`ifdef CART_RUMBLE_EN
  logic        rumble;
`endif

  always #5 hclk = ~hclk;

  cart_bus_responder dut (
    .hclk(hclk), .gbreset(gbreset),
    .cart_a(cart_a), .cart_cs_n(cart_cs_n), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n),
    .cart_d_in(cart_d_in), .cart_d_out(cart_d_out), .cart_d_oe(cart_d_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_ram(mem_sel_ram), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ram_en(ram_en)
`ifdef CART_RUMBLE_EN
    , .rumble(rumble)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int req_seen  = 0;
  int req_pushed = 0;
  int ack_delay = 3;
  logic [32:0] exp_req_q[$];
  logic [7:0]  exp_rd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic push_req(input logic we, input logic sel, input logic [22:0] addr, input logic [7:0] wd);
    exp_req_q.push_back({we, sel, addr, wd});
    req_pushed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hclk);
  endtask

  // memory model: ack after ack_delay waiting cycles, read data = addr[7:0] ^ 8'h93
  initial begin : mem_model
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge hclk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr[7:0] ^ 8'h93;
          wait_cnt  = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin : monitor
    logic req_p, oe_p;
    logic [32:0] act, exp;
    req_p = 1'b0;
    oe_p  = 1'b0;
    forever begin
      @(negedge hclk);
      if (mem_req && !req_p) begin
        req_seen++;
        act = {mem_we, mem_sel_ram, mem_addr, mem_we ? mem_wdata : 8'h00};
        if (exp_req_q.size() == 0) begin
          total_cnt++;
          $display("FAIL req_unexpected: got 0x%0h, required no request", act);
        end else begin
          exp = exp_req_q.pop_front();
          chk("mem_request", 64'(act), 64'(exp));
        end
      end
      if (cart_d_oe && !oe_p) begin
        if (exp_rd_q.size() == 0) begin
          total_cnt++;
          $display("FAIL oe_unexpected: got data 0x%0h, required no drive", cart_d_out);
        end else begin
          chk("cart_d_out", 64'(cart_d_out), 64'(exp_rd_q.pop_front()));
        end
      end
      req_p = mem_req;
      oe_p  = cart_d_oe;
    end
  end

  task automatic do_read(input logic [15:0] addr, input logic cs_n, input bit resp, input string name);
    bit bad;
    cart_a = addr; cart_cs_n = cs_n; cart_rd_n = 1'b0;
    if (resp) begin
      for (int i = 0; i < 80 && !cart_d_oe; i++) @(negedge hclk);
      chk({name, "_oe"}, 64'(cart_d_oe), 64'd1);
      tick(3);
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(negedge hclk);
        if (mem_req || cart_d_oe) bad = 1'b1;
      end
      chk({name, "_silent"}, 64'(bad), 64'd0);
    end
    cart_rd_n = 1'b1;
    tick(3);
    chk({name, "_oe_drop"}, 64'(cart_d_oe), 64'd0);
    cart_cs_n = 1'b1;
    tick(2);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] d, input logic cs_n);
    cart_a = addr; cart_d_in = d; cart_cs_n = cs_n; cart_wr_n = 1'b0;
    tick(6);
    cart_wr_n = 1'b1;
    tick(4);
    cart_cs_n = 1'b1; cart_d_in = 8'hFF;
    tick(12);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    gbreset = 1'b1; cart_a = 16'h0000; cart_cs_n = 1'b1; cart_rd_n = 1'b1; cart_wr_n = 1'b1;
    cart_d_in = 8'h00;
    tick(3);
    chk("reset_outputs",
        64'({mem_req, mem_we, mem_sel_ram, mem_addr, mem_wdata, cart_d_out, cart_d_oe, ram_en}), 64'd0);
    gbreset = 1'b0;
    tick(3);

    push_req(1'b0, 1'b0, 23'h000150, 8'h00); exp_rd_q.push_back(8'hC3);
    do_read(16'h0150, 1'b1, 1'b1, "rom0_0150");
    push_req(1'b0, 1'b0, 23'h003FFF, 8'h00); exp_rd_q.push_back(8'h6C);
    do_read(16'h3FFF, 1'b1, 1'b1, "rom0_3fff");

    do_read(16'hA000, 1'b0, 1'b0, "sram_gated");
    do_read(16'hC000, 1'b1, 1'b0, "unmapped");

    do_write(16'h2000, 8'h05, 1'b1);
    do_write(16'h3000, 8'h01, 1'b1);
    push_req(1'b0, 1'b0, 23'h414123, 8'h00); exp_rd_q.push_back(8'hB0);
    do_read(16'h4123, 1'b1, 1'b1, "romx_105");

    do_write(16'h0000, 8'h0A, 1'b1);
    chk("ram_en_set", 64'(ram_en), 64'd1);
    do_write(16'h4000, 8'h02, 1'b1);
    push_req(1'b1, 1'b1, 23'h004010, 8'h3C);
    do_write(16'hA010, 8'h3C, 1'b0);
    push_req(1'b0, 1'b1, 23'h004010, 8'h00); exp_rd_q.push_back(8'h83);
    do_read(16'hA010, 1'b0, 1'b1, "sram_rd");

    ack_delay = 8;
    push_req(1'b0, 1'b0, 23'h000100, 8'h00);
    push_req(1'b0, 1'b0, 23'h000101, 8'h00);
    exp_rd_q.push_back(8'h92);
    cart_a = 16'h0100; cart_rd_n = 1'b0;
    for (int i = 0; i < 40 && !mem_req; i++) @(negedge hclk);
    chk("midfetch_req", 64'(mem_req), 64'd1);
    tick(2);
    cart_a = 16'h0101;
    for (int i = 0; i < 80 && !cart_d_oe; i++) @(negedge hclk);
    chk("midfetch_oe", 64'(cart_d_oe), 64'd1);
    tick(3);
    cart_rd_n = 1'b1;
    tick(3);
    chk("midfetch_oe_drop", 64'(cart_d_oe), 64'd0);
    tick(4);

    ack_delay = 60;
    push_req(1'b0, 1'b0, 23'h000150, 8'h00);
    cart_a = 16'h0150; cart_rd_n = 1'b0;
    for (int i = 0; i < 40 && !mem_req; i++) @(negedge hclk);
    chk("rst_pre_req", 64'(mem_req), 64'd1);
    tick(1);
    gbreset = 1'b1;
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_oe", 64'(cart_d_oe), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    cart_rd_n = 1'b1; cart_a = 16'h0000;
    tick(3);
    gbreset = 1'b0;
    ack_delay = 3;
    tick(3);

    push_req(1'b0, 1'b0, 23'h004000, 8'h00); exp_rd_q.push_back(8'h93);
    do_read(16'h4000, 1'b1, 1'b1, "post_rst_bank1");

    do_write(16'h2000, 8'h00, 1'b1);
    push_req(1'b0, 1'b0, 23'h000001, 8'h00); exp_rd_q.push_back(8'h92);
    do_read(16'h4001, 1'b1, 1'b1, "bank0");

`ifdef CART_RUMBLE_EN
    do_write(16'h0000, 8'h0A, 1'b1);
    do_write(16'h4000, 8'h08, 1'b1);
    chk("rumble_on", 64'(rumble), 64'd1);
    push_req(1'b0, 1'b1, 23'h000005, 8'h00); exp_rd_q.push_back(8'h96);
    do_read(16'hA005, 1'b0, 1'b1, "rumble_rd");
`endif

    tick(5);
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("req_count", 64'(req_seen), 64'(req_pushed));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
